// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared types and constants for the FPU sqrt sequencer
package fpu_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} seq_state_t;
  localparam logic [31:0] QNAN = 32'h7FC00000;
endpackage

// File: rtl/fpu_operand_fifo.sv
// rtl/fpu_operand_fifo.sv - DEPTH x 32 synchronous operand FIFO with occupancy count
module fpu_operand_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [31:0]                  push_data,
  input  logic                         pop,
  output logic [31:0]                  head,
  output logic                         ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign ready   = (count < FULL);
  assign do_push = push && ready;
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers are exactly log2(DEPTH) wide so they wrap without extra logic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fpu_sqrt_sequencer.sv
// rtl/fpu_sqrt_sequencer.sv - queues operands and drives a start/done FPU one op at a time
// Optional WAIT timeout with qNaN/error response enabled by FPU_TIMEOUT_EN.
module fpu_sqrt_sequencer
  import fpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_data,
  output logic                         error,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         fpu_start,
  output logic [31:0]                  fpu_a,
  input  logic                         fpu_done,
  input  logic                         fpu_busy,
  input  logic [31:0]                  fpu_result
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
    $error("fpu_sqrt_sequencer: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  seq_state_t  state_q;
  seq_state_t  state_d;
  logic        pop;
  logic [31:0] head;

  fpu_operand_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (in_valid && in_ready),
    .push_data (in_data),
    .pop       (pop),
    .head      (head),
    .ready     (in_ready),
    .count     (fifo_count)
  );

`ifdef FPU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
  logic          timed_out;
  logic          error_q;
`endif

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
`ifdef FPU_TIMEOUT_EN
    timed_out = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (fifo_count != '0 && !fpu_busy) begin
          state_d = ISSUE;
          pop     = 1'b1;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (fpu_done) begin
          state_d = RESP;
        end
`ifdef FPU_TIMEOUT_EN
        else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          state_d   = RESP;
          timed_out = 1'b1;
        end
`endif
      end
      RESP: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      fpu_a    <= '0;
      out_data <= '0;
    end else begin
      state_q <= state_d;
      if (pop) fpu_a <= head;
      // A real completion wins over a timeout landing on the same cycle.
      if (state_q == WAIT && fpu_done) out_data <= fpu_result;
`ifdef FPU_TIMEOUT_EN
      else if (timed_out) out_data <= QNAN;
`endif
    end
  end

`ifdef FPU_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
      error_q <= 1'b0;
    end else begin
      if (state_q == ISSUE)     tmo_cnt <= '0;
      else if (state_q == WAIT) tmo_cnt <= tmo_cnt + TW'(1);
      if (timed_out)                          error_q <= 1'b1;
      else if (state_q == RESP && out_ready)  error_q <= 1'b0;
    end
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign fpu_start = (state_q == ISSUE);
  assign out_valid = (state_q == RESP);
endmodule

// File: tb/tb_fpu_sqrt_sequencer.sv
// tb/tb_fpu_sqrt_sequencer.sv - self-checking bench with FPU model and in-order scoreboard
// Timeout test compiled only with FPU_TIMEOUT_EN.
module tb_fpu_sqrt_sequencer;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        error;
  logic [2:0]  fifo_count;
  logic        fpu_start;
  logic [31:0] fpu_a;
  logic        fpu_done;
  logic        fpu_busy;
  logic [31:0] fpu_result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic        m_active = 1'b0;
  logic        m_done = 1'b0;
  logic        m_hang = 1'b0;
  logic        force_busy = 1'b0;
  logic        manual_done = 1'b0;
  int          m_cnt = 0;
  int          m_lat = 5;
  logic [31:0] m_op = '0;
  logic [31:0] m_res = '0;

  assign fpu_done   = m_done | manual_done;
  assign fpu_busy   = m_active | force_busy;
  assign fpu_result = m_res;

  fpu_sqrt_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .error(error), .fifo_count(fifo_count),
    .fpu_start(fpu_start), .fpu_a(fpu_a),
    .fpu_done(fpu_done), .fpu_busy(fpu_busy), .fpu_result(fpu_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Square roots of the directed operands; anything else gets an arbitrary bijection.
  function automatic logic [31:0] fpu_fn(input logic [31:0] x);
    case (x)
      32'h40800000: return 32'h40000000;
      32'h3F800000: return 32'h3F800000;
      32'h41100000: return 32'h40400000;
      32'h41800000: return 32'h40800000;
      default:      return {x[15:0], ~x[31:16]};
    endcase
  endfunction

  // FPU model: latches fpu_a on start, pulses done m_lat cycles later (never if m_hang).
  always @(negedge clk) begin
    m_done = 1'b0;
    if (m_active) begin
      m_cnt--;
      if (m_cnt <= 0) begin
        m_active = 1'b0;
        if (!m_hang) begin
          m_done = 1'b1;
          m_res  = fpu_fn(m_op);
        end
      end
    end else if (fpu_start) begin
      m_active = 1'b1;
      m_cnt    = m_lat;
      m_op     = fpu_a;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [31:0] op;
    logic [31:0] res;
  } vec_t;

  vec_t        tbl[3];
  logic [31:0] ops[5];
  logic [31:0] exp_q[$];
  logic [31:0] d0;
  int          c0, st_cyc, ov_cyc, starts, accepted, bad, k, last_cons, got, pushes;

  initial begin
    tbl[0] = '{op: 32'h3F800000, res: 32'h3F800000};
    tbl[1] = '{op: 32'h41100000, res: 32'h40400000};
    tbl[2] = '{op: 32'h41800000, res: 32'h40800000};

    // Reset in the middle of an operation
    do_reset();
    m_lat = 5;
    in_valid = 1'b1; in_data = 32'h12345678; tick();
    in_data = 32'h9ABCDEF0; tick();
    in_valid = 1'b0;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_fpu_start", 32'(fpu_start), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_fpu_a", fpu_a, 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid || fpu_start) bad++;
    end
    chk("rst_late_done_ignored", 32'(bad), 32'd0);

    // Single operand, latency and result
    do_reset();
    m_lat = 5;
    c0 = cyc; in_valid = 1'b1; in_data = 32'h40800000;
    tick(); in_valid = 1'b0;
    st_cyc = -1; ov_cyc = -1; starts = 0; d0 = '0;
    for (int i = 0; i < 40 && ov_cyc < 0; i++) begin
      if (fpu_start) begin
        starts++; st_cyc = cyc; d0 = fpu_a;
      end
      if (out_valid) ov_cyc = cyc;
      else tick();
    end
    chk("t2_start_count", 32'(starts), 32'd1);
    chk("t2_start_latency", 32'(st_cyc - c0), 32'd2);
    chk("t2_fpu_a", d0, 32'h40800000);
    chk("t2_out_latency", 32'(ov_cyc - c0), 32'd8);
    chk("t2_out_data", out_data, 32'h40000000);
    chk("t2_error", 32'(error), 32'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t2_consumed", 32'(out_valid), 32'd0);

    // Full FIFO while FPU busy
    force_busy = 1'b1; accepted = 0; m_lat = 3;
    for (int i = 0; i < 5; i++) begin
      ops[i] = $urandom;
      in_valid = 1'b1; in_data = ops[i];
      if (i == 4) chk("t3_ready_on_5th", 32'(in_ready), 32'd0);
      if (in_ready) accepted++;
      tick();
    end
    in_valid = 1'b0;
    chk("t3_accepted", 32'(accepted), 32'd4);
    chk("t3_count_full", 32'(fifo_count), 32'd4);
    chk("t3_ready_full", 32'(in_ready), 32'd0);
    force_busy = 1'b0;
    tick();
    chk("t3_ready_after_pop", 32'(in_ready), 32'd1);
    chk("t3_count_after_pop", 32'(fifo_count), 32'd3);
    out_ready = 1'b1; got = 0;
    for (int i = 0; i < 200 && got < 4; i++) begin
      if (out_valid) begin
        chk($sformatf("t3_result%0d", got), out_data, fpu_fn(ops[got]));
        got++;
      end
      tick();
    end
    out_ready = 1'b0;
    chk("t3_result_count", 32'(got), 32'd4);

    // Backpressure in RESP
    ops[0] = $urandom; ops[1] = $urandom;
    in_valid = 1'b1; in_data = ops[0]; tick();
    in_data = ops[1]; tick(); in_valid = 1'b0;
    for (int i = 0; i < 40 && !out_valid; i++) tick();
    d0 = out_data; bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!out_valid || out_data !== d0 || fpu_start) bad++;
    end
    chk("t4_first_result", d0, fpu_fn(ops[0]));
    chk("t4_stall_stable", 32'(bad), 32'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    for (int i = 0; i < 40 && !out_valid; i++) tick();
    chk("t4_second_result", out_data, fpu_fn(ops[1]));
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Table-driven in-order results, each start after the previous consume
    m_lat = 4; k = 0; pushes = 0; last_cons = -1; bad = 0; starts = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && k < 3; i++) begin
      if (fpu_start) begin
        if (starts > 0 && cyc <= last_cons) bad++;
        starts++;
      end
      if (out_valid) begin
        chk($sformatf("t5_result%0d", k), out_data, tbl[k].res);
        last_cons = cyc; k++;
      end
      if (pushes < 3 && in_ready) begin
        in_valid = 1'b1; in_data = tbl[pushes].op; pushes++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t5_result_count", 32'(k), 32'd3);
    chk("t5_start_after_consume", 32'(bad), 32'd0);

`ifdef FPU_TIMEOUT_EN
    // FPU never completes
    m_hang = 1'b1; m_lat = 2;
    in_valid = 1'b1; in_data = $urandom; tick(); in_valid = 1'b0;
    st_cyc = -1; ov_cyc = -1;
    for (int i = 0; i < 200 && ov_cyc < 0; i++) begin
      if (fpu_start) st_cyc = cyc;
      if (out_valid) ov_cyc = cyc;
      else tick();
    end
    chk("t6_timeout_latency", 32'(ov_cyc - st_cyc), 32'd65);
    chk("t6_qnan", out_data, 32'h7FC00000);
    chk("t6_error", 32'(error), 32'd1);
    manual_done = 1'b1; tick(); manual_done = 1'b0;
    chk("t6_late_done_resp", out_data, 32'h7FC00000);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t6_error_cleared", 32'(error), 32'd0);
    manual_done = 1'b1; tick(); manual_done = 1'b0; tick();
    chk("t6_late_done_idle", 32'(out_valid), 32'd0);
    m_hang = 1'b0;
`endif

    // Randomized traffic against an in-order scoreboard
    do_reset();
    exp_q.delete(); pushes = 0; starts = 0;
    for (int i = 0; i < 3000; i++) begin
      if (fpu_start) starts++;
      chk("rnd_fifo_count", 32'(fifo_count), 32'(pushes - starts));
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("rnd_unexpected_out", 32'(out_valid), 32'd0);
        else chk("rnd_out_data", out_data, exp_q.pop_front());
        chk("rnd_error", 32'(error), 32'd0);
      end
      in_valid = ($urandom_range(0, 1) == 1);
      in_data  = $urandom;
      if (in_valid && in_ready) begin
        exp_q.push_back(fpu_fn(in_data));
        pushes++;
      end
      m_lat = $urandom_range(1, 8);
      force_busy = ($urandom_range(0, 7) == 0);
      tick();
    end
    in_valid = 1'b0; force_busy = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 500 && exp_q.size() > 0; i++) begin
      if (out_valid) chk("rnd_drain_data", out_data, exp_q.pop_front());
      tick();
    end
    chk("rnd_all_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
